// File: rtl/subtractor_if.sv
// Operand/result bundle for the registered subtractor.
//   in_valid, A, B     : operand pair, qualified by in_valid
//   out_valid          : one-cycle strobe marking a fresh result
//   Diff               : A-B modulo 2^WIDTH
//   Borrow, Overflow   : unsigned borrow and signed overflow of A-B
//   Zero, Negative     : Diff == 0 and Diff MSB
// master drives operands and observes results; slave is the subtractor.
interface subtractor_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic [WIDTH-1:0] Diff;
  logic             Borrow;
  logic             Overflow;
  logic             Zero;
  logic             Negative;

  modport master (
    output in_valid, A, B,
    input  out_valid, Diff, Borrow, Overflow, Zero, Negative
  );

  modport slave (
    input  in_valid, A, B,
    output out_valid, Diff, Borrow, Overflow, Zero, Negative
  );
endinterface

// File: rtl/subtractor.sv
// Registered WIDTH-bit subtractor built from a ripple chain of full-subtractor
// cells. One-cycle latency, one operation per cycle, all outputs from flops.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : subtractor_if slave (operands in, result and flags out)
module subtractor #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  subtractor_if.slave  bus
);

  logic [WIDTH-1:0] w_diff;
  logic             w_borrow;
  logic             w_overflow;

  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
  logic             r_overflow;
  logic             r_zero;
  logic             r_negative;
  logic             r_valid;

  // Each cell keeps its own borrow net so the chain is a plain sequence of
  // scalar nets rather than a vector that feeds back into itself.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic w_bin;
    logic w_bout;
    if (i == 0) begin : g_lsb
      assign w_bin = 1'b0;
    end else begin : g_upper
      assign w_bin = g_cell[i-1].w_bout;
    end
    assign w_diff[i] = bus.A[i] ^ bus.B[i] ^ w_bin;
    assign w_bout    = (~bus.A[i] & bus.B[i]) | (~(bus.A[i] ^ bus.B[i]) & w_bin);
  end

  assign w_borrow   = g_cell[WIDTH-1].w_bout;
  // Signed overflow: operand signs differ and the result sign differs from A.
  assign w_overflow = (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]) &
                      (w_diff[WIDTH-1] ^ bus.A[WIDTH-1]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_diff     <= '0;
      r_borrow   <= 1'b0;
      r_overflow <= 1'b0;
      r_zero     <= 1'b1;
      r_negative <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      r_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_diff     <= w_diff;
        r_borrow   <= w_borrow;
        r_overflow <= w_overflow;
        r_zero     <= (w_diff == '0);
        r_negative <= w_diff[WIDTH-1];
      end
    end
  end

  assign bus.out_valid = r_valid;
  assign bus.Diff      = r_diff;
  assign bus.Borrow    = r_borrow;
  assign bus.Overflow  = r_overflow;
  assign bus.Zero      = r_zero;
  assign bus.Negative  = r_negative;

endmodule

// File: tb/tb_subtractor.sv
// Self-checking bench for subtractor: directed cases, reset behaviour,
// hold behaviour and an exhaustive A/B sweep with random idle gaps.
module tb_subtractor;

  typedef struct packed {
    logic [7:0] diff;
    logic       borrow;
    logic       ovf;
    logic       zero;
    logic       neg;
  } res_t;

  localparam res_t RST_RES = '{diff: 8'h00, borrow: 1'b0, ovf: 1'b0, zero: 1'b1, neg: 1'b0};

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  res_t sb[$];
  res_t last;

  subtractor_if #(.WIDTH(8)) bus ();

  subtractor #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic res_t model(input logic [7:0] a, input logic [7:0] b);
    res_t r;
    int   sd;
    sd       = int'($signed(a)) - int'($signed(b));
    r.diff   = a - b;
    r.borrow = (a < b);
    r.ovf    = (sd > 127) || (sd < -128);
    r.zero   = (r.diff == 8'h00);
    r.neg    = r.diff[7];
    return r;
  endfunction

  task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cmp_res(input string tag, input res_t e);
    cmp({tag, ".Diff"},     bus.Diff,            e.diff);
    cmp({tag, ".Borrow"},   {7'd0, bus.Borrow},   {7'd0, e.borrow});
    cmp({tag, ".Overflow"}, {7'd0, bus.Overflow}, {7'd0, e.ovf});
    cmp({tag, ".Zero"},     {7'd0, bus.Zero},     {7'd0, e.zero});
    cmp({tag, ".Negative"}, {7'd0, bus.Negative}, {7'd0, e.neg});
  endtask

  // One clock of stimulus: drive at negedge, check 1 ns after the rising edge.
  task automatic step(input string tag, input logic rst, input logic v,
                      input logic [7:0] a, input logic [7:0] b);
    res_t e;
    @(negedge clk);
    rst_n        = ~rst;
    bus.in_valid = v;
    bus.A        = a;
    bus.B        = b;
    if (v && !rst) sb.push_back(model(a, b));
    @(posedge clk);
    #1;
    if (rst) begin
      sb.delete();
      last = RST_RES;
      cmp({tag, ".out_valid"}, {7'd0, bus.out_valid}, 8'd0);
      cmp_res(tag, RST_RES);
    end else if (v) begin
      cmp({tag, ".out_valid"}, {7'd0, bus.out_valid}, 8'd1);
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL %s.scoreboard observed=empty expected=entry", tag);
      end
      if (sb.size() != 0) begin
        e    = sb.pop_front();
        last = e;
        cmp_res(tag, e);
      end
    end else begin
      cmp({tag, ".out_valid"}, {7'd0, bus.out_valid}, 8'd0);
      cmp_res(tag, last);
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    last         = RST_RES;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.A        = '0;
    bus.B        = '0;

    step("reset0", 1'b1, 1'b0, 8'h00, 8'h00);
    step("reset1", 1'b1, 1'b0, 8'h00, 8'h00);

    step("0-1",    1'b0, 1'b1, 8'h00, 8'h01);
    step("7F-80",  1'b0, 1'b1, 8'h7F, 8'h80);
    step("80-7F",  1'b0, 1'b1, 8'h80, 8'h7F);
    step("40-C0",  1'b0, 1'b1, 8'h40, 8'hC0);
    step("C0-40",  1'b0, 1'b1, 8'hC0, 8'h40);
    step("FF-FF",  1'b0, 1'b1, 8'hFF, 8'hFF);
    step("80-80",  1'b0, 1'b1, 8'h80, 8'h80);
    step("00-00",  1'b0, 1'b1, 8'h00, 8'h00);
    step("0F-01",  1'b0, 1'b1, 8'h0F, 8'h01);
    step("F0-0F",  1'b0, 1'b1, 8'hF0, 8'h0F);

    step("01-FF",  1'b0, 1'b1, 8'h01, 8'hFF);
    for (int i = 0; i < 3; i++) step("hold", 1'b0, 1'b0, 8'hAA, 8'h55);

    step("pre_rst",  1'b0, 1'b1, 8'h33, 8'h11);
    step("rst_valid", 1'b1, 1'b1, 8'h12, 8'h34);
    step("post_rst_idle", 1'b0, 1'b0, 8'h12, 8'h34);
    step("post_rst", 1'b0, 1'b1, 8'h12, 8'h34);

    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 256; b++) begin
        if ($urandom_range(15) == 0) step("sweep_gap", 1'b0, 1'b0, 8'h00, 8'h00);
        step("sweep", 1'b0, 1'b1, 8'(a), 8'(b));
      end
    end

    @(negedge clk);
    bus.in_valid = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
